// File: rtl/display_pkg.sv
// Shared constants for the binary display path: digit count, scheduler FSM states,
// and the segment codes the display decoder uses for a single 0/1 digit.
package display_pkg;
  localparam int unsigned DISP_W = 14;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam logic [6:0] SEG_ZERO = 7'b0000001;
  localparam logic [6:0] SEG_ONE  = 7'b1001111;
endpackage

// File: rtl/rr_next_picker.sv
// Combinational round-robin search: next set bit of valid_i after cur_i, wrapping,
// with cur_i itself examined last so a lone valid source selects itself.
module rr_next_picker
  import display_pkg::*;
#(
  parameter  int unsigned N_SRC = 4,
  localparam int unsigned IW    = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] valid_i,
  input  logic [IW-1:0]    cur_i,
  output logic [IW-1:0]    next_o,
  output logic             any_valid_o
);

  int unsigned idx;
  logic        found;

  always_comb begin
    next_o = cur_i;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      idx = (32'(cur_i) + k) % N_SRC;
      if (!found && valid_i[IW'(idx)]) begin
        next_o = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_valid_o = |valid_i;

endmodule

// File: rtl/display_scheduler.sv
// Round-robin time-sharing of the binary display among N_SRC CPU value sources.
// Optional MANUAL_SEL_EN adds manual_en/manual_sel to pin one source on the display.
module display_scheduler
  import display_pkg::*;
#(
  parameter int unsigned N_SRC        = 4,
  parameter int unsigned WIDTH        = DISP_W,
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef MANUAL_SEL_EN
  input  logic                       manual_en,
  input  logic [$clog2(N_SRC)-1:0]   manual_sel,
`endif
  input  logic [N_SRC*WIDTH-1:0]     src_data,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic                       advance,
  input  logic                       freeze,
  output logic [WIDTH-1:0]           display_value,
  output logic [$clog2(N_SRC)-1:0]   active_src,
  output logic                       display_valid,
  output logic                       dwell_tick
);

  localparam int unsigned IW    = $clog2(N_SRC);
  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);

  state_e           state_q, state_d;
  logic [IW-1:0]    active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] disp_q;
  logic             valid_q, tick_q, tick_d;

  logic [IW-1:0]    cur_sel, next_idx;
  logic             any_valid, expire;
  logic             man_en;
  logic [IW-1:0]    man_sel;
  logic [WIDTH-1:0] src_arr [N_SRC];

`ifdef MANUAL_SEL_EN
  assign man_en  = manual_en;
  assign man_sel = manual_sel;
`else
  assign man_en  = 1'b0;
  assign man_sel = '0;
`endif

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign src_arr[g] = src_data[g*WIDTH +: WIDTH];
  end

  // In IDLE, searching "after N_SRC-1" yields the lowest valid index.
  assign cur_sel = (state_q == SHOW) ? active_q : IW'(N_SRC - 1);
  assign expire  = (cnt_q == CNT_W'(DWELL_CYCLES - 1)) && !freeze;

  rr_next_picker #(.N_SRC(N_SRC)) u_picker (
    .valid_i     (src_valid),
    .cur_i       (cur_sel),
    .next_o      (next_idx),
    .any_valid_o (any_valid)
  );

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    if (man_en) begin
      state_d  = SHOW;
      active_d = man_sel;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            state_d  = SHOW;
            active_d = next_idx;
            cnt_d    = '0;
          end
        end
        SHOW: begin
          if (!src_valid[active_q]) begin
            cnt_d = '0;
            if (any_valid) begin
              active_d = next_idx;
            end else begin
              state_d  = IDLE;
              active_d = '0;
            end
          end else if (advance || expire) begin
            active_d = next_idx;
            cnt_d    = '0;
            tick_d   = expire;
          end else if (!freeze) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output data follows the next-state index so value and active_src stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      active_q <= '0;
      cnt_q    <= '0;
      disp_q   <= '0;
      valid_q  <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      disp_q   <= (state_d == SHOW) ? src_arr[active_d] : '0;
      valid_q  <= (state_d == SHOW);
      tick_q   <= tick_d;
    end
  end

  assign display_value = disp_q;
  assign active_src    = active_q;
  assign display_valid = valid_q;
  assign dwell_tick    = tick_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with N_SRC=4, DWELL_CYCLES=4, data i = 14'h0100*i+1.
module tb_display_scheduler;
  localparam int unsigned N = 4;
  localparam int unsigned W = 14;
  localparam int unsigned D = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_valid;
  logic           advance, freeze;
  logic [W-1:0]   display_value;
  logic [1:0]     active_src;
  logic           display_valid, dwell_tick;
`ifdef MANUAL_SEL_EN
  logic           manual_en;
  logic [1:0]     manual_sel;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  valid;
    logic        adv;
    logic        frz;
    logic [1:0]  src;
    logic        tick;
    logic [13:0] val;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  display_scheduler #(.N_SRC(N), .WIDTH(W), .DWELL_CYCLES(D)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef MANUAL_SEL_EN
    .manual_en     (manual_en),
    .manual_sel    (manual_sel),
`endif
    .src_data      (src_data),
    .src_valid     (src_valid),
    .advance       (advance),
    .freeze        (freeze),
    .display_value (display_value),
    .active_src    (active_src),
    .display_valid (display_valid),
    .dwell_tick    (dwell_tick)
  );

  function automatic logic [13:0] dval(input int unsigned i);
    return 14'(32'h0100 * i + 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] v, input logic a, input logic f,
                     input int unsigned s, input logic t);
    vec_t e;
    e.valid = v;
    e.adv   = a;
    e.frz   = f;
    e.src   = 2'(s);
    e.tick  = t;
    e.val   = dval(s);
    vecs.push_back(e);
  endtask

  task automatic chk_all(input string tag, input logic [1:0] s, input logic v,
                         input logic t, input logic [13:0] val);
    chk({tag, ".src"},   32'(active_src),    32'(s));
    chk({tag, ".valid"}, 32'(display_valid), 32'(v));
    chk({tag, ".tick"},  32'(dwell_tick),    32'(t));
    chk({tag, ".value"}, 32'(display_value), 32'(val));
  endtask

  // One dwell period starting on a tick into s: tick cycle plus three plain cycles.
  task automatic period(input logic [3:0] v, input int unsigned s);
    add(v, 1'b0, 1'b0, s, 1'b1);
    repeat (3) add(v, 1'b0, 1'b0, s, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    src_valid = 4'hF;
    advance   = 1'b0;
    freeze    = 1'b0;
`ifdef MANUAL_SEL_EN
    manual_en  = 1'b0;
    manual_sel = 2'd0;
`endif
    for (int i = 0; i < N; i++) src_data[i*W +: W] = dval(i);

    // Round robin over all four sources
    repeat (4) add(4'hF, 1'b0, 1'b0, 0, 1'b0);
    period(4'hF, 1); period(4'hF, 2); period(4'hF, 3);
    add(4'hF, 1'b0, 1'b0, 0, 1'b1);
    // Mask 1010: drop of src 0 moves to 1, then 3,1,3
    repeat (4) add(4'hA, 1'b0, 1'b0, 1, 1'b0);
    period(4'hA, 3); period(4'hA, 1);
    add(4'hA, 1'b0, 1'b0, 3, 1'b1);
    // Single valid source stays and still ticks
    repeat (4) add(4'h4, 1'b0, 1'b0, 2, 1'b0);
    period(4'h4, 2);
    add(4'h4, 1'b0, 1'b0, 2, 1'b1);
    // Back to all valid, land on src 0 at cnt 0
    repeat (3) add(4'hF, 1'b0, 1'b0, 2, 1'b0);
    period(4'hF, 3);
    add(4'hF, 1'b0, 1'b0, 0, 1'b1);
    // Advance at cnt 1: no tick, full dwell afterwards
    add(4'hF, 1'b0, 1'b0, 0, 1'b0);
    add(4'hF, 1'b1, 1'b0, 1, 1'b0);
    repeat (3) add(4'hF, 1'b0, 1'b0, 1, 1'b0);
    add(4'hF, 1'b0, 1'b0, 2, 1'b1);
    // Advance coincident with expiry: single step with tick
    repeat (3) add(4'hF, 1'b0, 1'b0, 2, 1'b0);
    add(4'hF, 1'b1, 1'b0, 3, 1'b1);
    repeat (3) add(4'hF, 1'b0, 1'b0, 3, 1'b0);
    add(4'hF, 1'b0, 1'b0, 0, 1'b1);
    // Freeze 10 cycles on src 2
    repeat (3) add(4'hF, 1'b0, 1'b0, 0, 1'b0);
    period(4'hF, 1);
    add(4'hF, 1'b0, 1'b0, 2, 1'b1);
    repeat (10) add(4'hF, 1'b0, 1'b1, 2, 1'b0);
    repeat (3) add(4'hF, 1'b0, 1'b0, 2, 1'b0);
    add(4'hF, 1'b0, 1'b0, 3, 1'b1);
    // Advance overrides freeze
    add(4'hF, 1'b1, 1'b1, 0, 1'b0);

    repeat (3) begin
      step();
      chk_all("reset", 2'd0, 1'b0, 1'b0, 14'h0);
    end
    reset = 1'b0;

    foreach (vecs[i]) begin
      src_valid = vecs[i].valid;
      advance   = vecs[i].adv;
      freeze    = vecs[i].frz;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].src, 1'b1, vecs[i].tick, vecs[i].val);
    end
    advance = 1'b0;
    freeze  = 1'b0;

    // Live data tracking on src 0 (cnt 0)
    src_data[0 +: W] = 14'h2ABC;
    chk("live.before", 32'(display_value), 32'(14'h0001));
    step();
    chk_all("live.after", 2'd0, 1'b1, 1'b0, 14'h2ABC);
    src_data[0 +: W] = dval(0);
    step();
    chk_all("live.restore", 2'd0, 1'b1, 1'b0, 14'h0001);

    // Drop active source, then all sources
    src_valid = 4'b0110;
    step();
    chk_all("drop.active", 2'd1, 1'b1, 1'b0, dval(1));
    src_valid = 4'b0000;
    step();
    chk("drop.all.valid", 32'(display_valid), 32'(1'b0));
    chk("drop.all.value", 32'(display_value), 32'(14'h0));
    advance = 1'b1;
    freeze  = 1'b1;
    step();
    chk("idle.adv.valid", 32'(display_valid), 32'(1'b0));
    chk("idle.adv.tick",  32'(dwell_tick),    32'(1'b0));
    advance   = 1'b0;
    freeze    = 1'b0;
    src_valid = 4'b0110;
    step();
    chk_all("idle.exit", 2'd1, 1'b1, 1'b0, dval(1));
    step();
    step();

    // Reset mid-dwell
    reset = 1'b1;
    step();
    chk_all("midreset", 2'd0, 1'b0, 1'b0, 14'h0);
    reset = 1'b0;
    step();
    chk_all("postreset", 2'd1, 1'b1, 1'b0, dval(1));
    repeat (3) begin
      step();
      chk_all("postreset.hold", 2'd1, 1'b1, 1'b0, dval(1));
    end
    step();
    chk_all("postreset.tick", 2'd2, 1'b1, 1'b1, dval(2));

`ifdef MANUAL_SEL_EN
    manual_en  = 1'b1;
    manual_sel = 2'd3;
    src_valid  = 4'b0000;
    step();
    chk_all("manual.enter", 2'd3, 1'b1, 1'b0, dval(3));
    for (int i = 0; i < 6; i++) begin
      advance = (i == 2);
      step();
      chk_all("manual.hold", 2'd3, 1'b1, 1'b0, dval(3));
    end
    advance   = 1'b0;
    manual_en = 1'b0;
    step();
    chk("manual.release.valid", 32'(display_valid), 32'(1'b0));
    chk("manual.release.value", 32'(display_value), 32'(14'h0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
